// File: rtl/fp16_pkg.sv
// Shared FP16 types, accumulation-sequencer states and helpers.
package fp16_pkg;

  typedef logic [15:0] fp16_t;

  typedef enum logic [2:0] {ACCEPT, ISSUE, ARM, WAIT, OUT} acc_state_e;

  localparam fp16_t       FP16_ZERO    = 16'h0000;
  localparam logic [14:0] FP16_MAX_MAG = 15'h7BFF;

  // Both +0 and -0 count as zero; the sign bit is ignored.
  function automatic logic fp16_is_zero(input fp16_t x);
    return (x[14:0] == 15'd0);
  endfunction

endpackage

// File: rtl/fp16_acc_seq.sv
// FP16 accumulation sequencer: one add per nonzero term, one result per LEN terms.
// Latency: 1 cycle per skipped term, 3 + adder latency per add; backpressure: holds OUT until out_ready. Macro FP16_ACC_SAT_EN saturates on overflow.
module fp16_acc_seq
  import fp16_pkg::*;
#(
  parameter int LEN   = 16,
  parameter int CNT_W = $clog2(LEN + 1)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        add_st,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic        add_done,
  input  logic        add_ovf,
  input  logic        add_unf,
  input  logic [15:0] add_sum
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN);

  acc_state_e       state, state_nxt;
  fp16_t            acc, a_q, b_q;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             first, ovf_abort, ovf_q, unf_q;
  logic             skip, accept, wait_hit, take;

  assign cnt_inc  = cnt + CNT_W'(1);
  assign skip     = first | fp16_is_zero(in_data) | ovf_abort;
  assign accept   = (state == ACCEPT) && in_valid;
  assign wait_hit = (state == WAIT) && (add_done | add_ovf);
  assign take     = (state == OUT) && out_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= ACCEPT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCEPT: if (in_valid) state_nxt = !skip ? ISSUE : ((cnt_inc == LAST) ? OUT : ACCEPT);
      ISSUE:  state_nxt = ARM;
      // done/ovf seen here are leftovers from the previous add
      ARM:    state_nxt = WAIT;
      WAIT:   if (add_done | add_ovf) state_nxt = (cnt == LAST) ? OUT : ACCEPT;
      OUT:    if (out_ready) state_nxt = ACCEPT;
      default: state_nxt = ACCEPT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc       <= FP16_ZERO;
      a_q       <= FP16_ZERO;
      b_q       <= FP16_ZERO;
      cnt       <= '0;
      first     <= 1'b1;
      ovf_abort <= 1'b0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      if (accept) begin
        cnt <= cnt_inc;
        a_q <= acc;
        b_q <= in_data;
        if (first) begin
          acc   <= in_data;
          first <= 1'b0;
        end
      end
      if (wait_hit) begin
        if (add_ovf) begin
          ovf_q <= 1'b1;
`ifdef FP16_ACC_SAT_EN
          acc <= {b_q[15], FP16_MAX_MAG};
`else
          ovf_abort <= 1'b1;
`endif
        end else begin
          acc   <= add_sum;
          unf_q <= unf_q | add_unf;
        end
      end
      if (take) begin
        acc       <= FP16_ZERO;
        cnt       <= '0;
        first     <= 1'b1;
        ovf_abort <= 1'b0;
        ovf_q     <= 1'b0;
        unf_q     <= 1'b0;
      end
    end
  end

  assign in_ready  = (state == ACCEPT);
  assign out_valid = (state == OUT);
  assign out_data  = out_valid ? acc : FP16_ZERO;
  assign out_ovf   = ovf_q;
  assign out_unf   = unf_q;
  assign add_st    = (state == ISSUE);
  assign add_a     = a_q;
  assign add_b     = b_q;

endmodule

// File: tb/tb_fp16_acc_seq.sv
// Directed bench for fp16_acc_seq (LEN=4) with a behavioural st/done adder model.
module tb_fp16_acc_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, out_valid, out_ready, out_ovf, out_unf;
  logic [15:0] in_data, out_data, add_a, add_b, add_sum;
  logic        add_st, add_done, add_ovf, add_unf;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  fp16_acc_seq #(.LEN(4)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_unf(out_unf),
    .add_st(add_st), .add_a(add_a), .add_b(add_b),
    .add_done(add_done), .add_ovf(add_ovf), .add_unf(add_unf), .add_sum(add_sum)
  );

  // Adder model: programmed responses, result 4 cycles after st, levels held.
  logic [15:0] resp_sum[$];
  bit          resp_ovf[$];
  bit          resp_unf[$];
  logic [15:0] st_a[$];
  logic [15:0] st_b[$];
  int          st_count = 0;
  int          wide_err = 0;
  bit          stale_mode = 0;
  logic        prev_st = 1'b0;
  logic        m_busy = 1'b0, m_clr = 1'b0;
  logic [2:0]  m_cnt = 3'd0;

  always @(posedge clk) begin
    prev_st <= add_st;
    if (add_st && prev_st) wide_err <= wide_err + 1;
    if (reset) begin
      add_done <= 1'b0; add_ovf <= 1'b0; add_unf <= 1'b0; add_sum <= 16'h0;
      m_busy <= 1'b0; m_clr <= 1'b0; m_cnt <= 3'd0;
    end else if (add_st) begin
      st_count <= st_count + 1;
      st_a.push_back(add_a);
      st_b.push_back(add_b);
      if (stale_mode) m_clr <= 1'b1;
      else begin add_done <= 1'b0; add_ovf <= 1'b0; end
      m_busy <= 1'b1;
      m_cnt  <= 3'd0;
    end else begin
      if (m_clr) begin add_done <= 1'b0; add_ovf <= 1'b0; m_clr <= 1'b0; end
      if (m_busy) begin
        m_cnt <= m_cnt + 3'd1;
        if (m_cnt == 3'd3) begin
          m_busy <= 1'b0;
          if (resp_sum.size() > 0) begin
            add_sum  <= resp_sum.pop_front();
            add_ovf  <= resp_ovf[0];
            add_done <= !resp_ovf[0];
            add_unf  <= resp_unf[0];
            void'(resp_ovf.pop_front());
            void'(resp_unf.pop_front());
          end else begin
            add_done <= 1'b1;
            add_sum  <= 16'hDEAD;
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push_resp(input logic [15:0] s, input bit o, input bit u);
    resp_sum.push_back(s);
    resp_ovf.push_back(o);
    resp_unf.push_back(u);
  endtask

  task automatic send_term(input logic [15:0] d);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) check("in_ready_timeout", {15'd0, in_ready}, 16'd1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 300) begin @(negedge clk); n++; end
    check(tag, {15'd0, out_valid}, 16'd1);
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    int base_cnt, base_q;
    logic [15:0] held;
    reset = 1'b1; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {15'd0, in_ready}, 16'd1);
    check("rst_out_valid", {15'd0, out_valid}, 16'd0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_flags", {14'd0, out_ovf, out_unf}, 16'd0);
    check("rst_add_st", {15'd0, add_st}, 16'd0);
    check("rst_add_ab", add_a | add_b, 16'h0000);
    reset = 1'b0;

    // 1: basic sequencing
    push_resp(16'h4200, 0, 0); push_resp(16'h4500, 0, 0); push_resp(16'h4700, 0, 0);
    base_cnt = st_count; base_q = st_a.size();
    send_term(16'h3C00); send_term(16'h4000); send_term(16'h4200); send_term(16'h4400);
    wait_out("t1_valid");
    check("t1_st_count", 16'(st_count - base_cnt), 16'd3);
    check("t1_st_width", 16'(wide_err), 16'd0);
    check("t1_first_a", st_a[base_q], 16'h3C00);
    check("t1_first_b", st_b[base_q], 16'h4000);
    check("t1_out_data", out_data, 16'h4700);
    check("t1_flags", {14'd0, out_ovf, out_unf}, 16'd0);
    take_out();

    // 2: zero skip
    push_resp(16'h4200, 0, 0);
    base_cnt = st_count;
    send_term(16'h3C00); send_term(16'h0000); send_term(16'h8000); send_term(16'h4000);
    wait_out("t2_valid");
    check("t2_st_count", 16'(st_count - base_cnt), 16'd1);
    check("t2_out_data", out_data, 16'h4200);
    take_out();

    // 3: stale done held across st; also an underflow on the middle add
    stale_mode = 1;
    push_resp(16'h4A00, 0, 0); push_resp(16'h4B00, 0, 1); push_resp(16'h4C00, 0, 0);
    base_q = st_a.size();
    send_term(16'h3C00); send_term(16'h4000); send_term(16'h4200); send_term(16'h4400);
    wait_out("t3_valid");
    check("t3_second_a", st_a[base_q+1], 16'h4A00);
    check("t3_third_a", st_a[base_q+2], 16'h4B00);
    check("t3_out_data", out_data, 16'h4C00);
    check("t3_out_unf", {15'd0, out_unf}, 16'd1);
    take_out();
    stale_mode = 0;

    // 4: overflow on the second add
    push_resp(16'h4200, 0, 0); push_resp(16'h7C00, 1, 0);
`ifdef FP16_ACC_SAT_EN
    push_resp(16'h7BFF, 0, 0);
`endif
    base_cnt = st_count; base_q = st_a.size();
    send_term(16'h3C00);
    check("t4_unf_cleared", {15'd0, out_unf}, 16'd0);
    send_term(16'h4000); send_term(16'h4200); send_term(16'h4400);
    wait_out("t4_valid");
    check("t4_out_ovf", {15'd0, out_ovf}, 16'd1);
`ifdef FP16_ACC_SAT_EN
    check("t4_st_count", 16'(st_count - base_cnt), 16'd3);
    check("t4_sat_a", st_a[base_q+2], 16'h7BFF);
    check("t4_sat_b", st_b[base_q+2], 16'h4400);
    held = 16'h7BFF;
`else
    check("t4_st_count", 16'(st_count - base_cnt), 16'd2);
    held = 16'h4200;
`endif
    check("t4_out_data", out_data, held);

    // 5: output backpressure on the overflowed result
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("t5_hold_valid", {15'd0, out_valid}, 16'd1);
      check("t5_hold_data", out_data, held);
      check("t5_hold_in_ready", {15'd0, in_ready}, 16'd0);
    end
    take_out();
    check("t5_released", {14'd0, out_valid, in_ready}, 16'd1);
    send_term(16'h3C00); send_term(16'h0000); send_term(16'h8000); send_term(16'h0000);
    wait_out("t5_fresh_valid");
    check("t5_fresh_data", out_data, 16'h3C00);
    check("t5_fresh_flags", {14'd0, out_ovf, out_unf}, 16'd0);
    take_out();

    // 6: reset while waiting on the adder
    push_resp(16'h5555, 0, 0);
    send_term(16'h3C00); send_term(16'h4000);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    resp_sum.delete(); resp_ovf.delete(); resp_unf.delete();
    check("t6_out_valid", {15'd0, out_valid}, 16'd0);
    check("t6_add_st", {15'd0, add_st}, 16'd0);
    check("t6_in_ready", {15'd0, in_ready}, 16'd1);
    check("t6_cnt", 16'(dut.cnt), 16'd0);
    push_resp(16'h4200, 0, 0); push_resp(16'h4500, 0, 0); push_resp(16'h4700, 0, 0);
    base_q = st_a.size();
    send_term(16'h3C00); send_term(16'h4000); send_term(16'h4200); send_term(16'h4400);
    wait_out("t6_valid");
    check("t6_first_a", st_a[base_q], 16'h3C00);
    check("t6_out_data", out_data, 16'h4700);
    check("t6_flags", {14'd0, out_ovf, out_unf}, 16'd0);
    take_out();
    check("end_st_width", 16'(wide_err), 16'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fp16_acc_seq.md
Name: fp16_acc_seq

Overview:
Accumulation sequencer placed directly upstream of the dnnCpu FP16 adder (st/done handshake adder). It accepts a stream of FP16 terms, such as products from the multiplier, and issues one add per term to the adder. It holds the running sum, collects the adder's overflow and underflow flags, and presents one FP16 dot-product result every LEN terms on a valid/ready output.

Parameters:
LEN, 16, number of terms per accumulation (must be ≥ 1)
CNT_W, $clog2(LEN+1), width of the term counter

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  term available
in_ready  out  1  sequencer can accept a term this cycle
in_data  in  16  FP16 term {sign, exp[4:0], frac[9:0]}
out_valid  out  1  accumulation result available
out_ready  in  1  consumer takes the result
out_data  out  16  accumulated FP16 sum
out_ovf  out  1  sticky: an add overflowed during this accumulation
out_unf  out  1  sticky: an add underflowed during this accumulation
add_st  out  1  one-cycle start pulse to the adder
add_a  out  16  adder operand 1 (running sum)
add_b  out  16  adder operand 2 (term)
add_done  in  1  adder done (level; held until the next start)
add_ovf  in  1  adder overflow (level; held until the next start)
add_unf  in  1  adder underflow (level)
add_sum  in  16  adder result (valid when add_done=1)

Behaviour:
- Reset (clk edge with reset=1), values take effect next cycle:
  - state=ACCEPT; acc=0; cnt=0; first=1.
  - in_ready=1 (combinational from state); out_valid=0; out_data=0; out_ovf=0; out_unf=0.
  - add_st=0; add_a=0; add_b=0.
  - The adder shares the same reset, so a reset mid-add aborts cleanly. No pending start may survive reset.
- States: ACCEPT, ISSUE, ARM, WAIT, OUT.
- ACCEPT (in_ready=1): on in_valid, register term and cnt←cnt+1. Then:
  - first=1: acc←term, first←0, no add. This avoids the adder's zero-operand handling.
  - term is ±0 (in_data[14:0]==0): no add; acc unchanged.
  - ovf_abort=1 (see Optional Feature): no add; term is drained.
  - otherwise: go to ISSUE.
  - After any of the no-add cases: if cnt reaches LEN, go to OUT; else stay in ACCEPT.
- ISSUE: add_st=1 for exactly one cycle; add_a=acc and add_b=term held stable from ISSUE until WAIT exits. Go to ARM.
- ARM: one cycle in which add_done/add_ovf are ignored, because they are stale levels from the previous add; the adder clears them on accepting st. Go to WAIT.
- WAIT: stay until add_done|add_ovf.
  - add_done=1: acc←add_sum; out_unf|=add_unf.
  - add_ovf=1: out_ovf←1; handled per Optional Feature.
  - If both are high, ovf wins.
  - Then go to OUT if cnt==LEN, else ACCEPT.
- OUT: out_valid=1, out_data=acc; in_ready=0.
  - On out_ready: out_valid←0; acc, cnt, first, ovf_abort, out_ovf and out_unf all cleared at that same edge; go to ACCEPT.
  - out_data is held until then.
- Throughput: 1 cycle per skipped term; otherwise 1 (accept) + 2 (ISSUE, ARM) + adder latency per term.
- No timeout: a hung adder stalls the sequencer until reset.

Optional Feature:
FP16_ACC_SAT_EN
- Defined: on add_ovf, acc←{add_b[15], 15'h7BFF} (overflow only occurs with like signs), and accumulation continues normally.
- Undefined: on add_ovf, acc keeps its pre-add value and ovf_abort←1. Remaining terms are accepted one per cycle with no add issued. out_data is the last good sum; out_ovf=1.

Decomposition:
- Package fp16_pkg:
  - typedef fp16_t (logic [15:0]);
  - enum acc_state_e {ACCEPT, ISSUE, ARM, WAIT, OUT};
  - constants FP16_ZERO=16'h0000, FP16_MAX_MAG=15'h7BFF;
  - function fp16_is_zero.
- No sub-module: a single FSM plus counter. The adder is instantiated beside this block at the parent level, not inside it.

Test Plan:
All cases use LEN=4. The bench models the adder (returns a programmed add_sum after 4 cycles; done/ovf held as levels).
1. Basic sequencing:
   - Stimulus: terms 0x3C00, 0x4000, 0x4200, 0x4400; model sums 0x4200, 0x4500, 0x4700.
   - Required: exactly 3 add_st pulses, each one cycle wide. First pulse has add_a=0x3C00, add_b=0x4000. out_data=0x4700; out_ovf=0; out_unf=0.
2. Zero skip:
   - Stimulus: terms 0x3C00, 0x0000, 0x8000, 0x4000; model sum 0x4200.
   - Required: exactly one add_st; out_data=0x4200.
3. Stale done:
   - Stimulus: model keeps add_done=1 from the previous add and clears it one cycle after st.
   - Required: sequencer does not latch the stale add_sum; acc takes the new result.
4. Overflow on 2nd add, model add_b sign=0:
   - Macro off: out_ovf=1, out_data equals sum after the 1st add, and no add_st for term 4.
   - Macro on: acc=0x7BFF after the overflow and add_st is issued for term 4.
5. Output backpressure:
   - Stimulus: out_ready=0 for 10 cycles.
   - Required: out_valid and out_data held stable, in_ready=0; after out_ready, the next term starts a fresh accumulation with out_ovf/out_unf cleared.
6. Reset in WAIT:
   - Stimulus: assert reset while in WAIT.
   - Required: next cycle out_valid=0, add_st=0, in_ready=1, cnt=0; the following 4 terms produce a correct fresh sum.
